// File: rtl/apb_uart_tx_if.sv
// APB3 bus bundle for the UART transmitter slave.
// The CPU side drives the master modport; the peripheral uses the slave modport.
interface apb_uart_tx_if;
    logic [3:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_uart_tx.sv
// APB3 zero-wait-state UART transmitter: byte FIFO drained by an 8N1 serializer.
// Registers: 0x0 TXDATA (push), 0x4 STATUS, 0x8 CTRL (tx_en).
module apb_uart_tx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    apb_uart_tx_if.slave  apb,
    output logic          tx,
    output logic          tx_busy
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH    = FIFO_DEPTH[AW:0];
    localparam logic [CW-1:0] BAUD_END = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic          tx_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          en_q;

    logic acc, wr, full, empty, pop, push_req, push_ok, drop, clr_ovf, baud_last;
    logic [31:0] cnt_w, rdata;
    logic [3:0]  cnt_sat;

    assign acc       = apb.PSEL & apb.PENABLE;
    assign wr        = acc & apb.PWRITE;
    assign full      = (cnt_q == DEPTH);
    assign empty     = (cnt_q == '0);
    assign pop       = (state_q == IDLE) & en_q & ~empty;
    assign push_req  = wr & (apb.PADDR == 4'h0);
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & ~push_ok;
    assign clr_ovf   = wr & (apb.PADDR == 4'h4) & apb.PWDATA[3];
    assign baud_last = (baud_q == BAUD_END);

    assign cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    assign ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            en_q   <= 1'b1;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (wr && apb.PADDR == 4'h8) en_q <= apb.PWDATA[0];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= apb.PWDATA[7:0];
    end

    // Serializer; tx is registered so every bit lasts exactly DIV clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        sh_q    <= mem_q[rptr_q];
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);

    assign cnt_w   = 32'(cnt_q);
    assign cnt_sat = (cnt_w > 32'd15) ? 4'hF : cnt_w[3:0];

    always_comb begin
        rdata = '0;
        case (apb.PADDR)
            4'h4:    rdata = {24'd0, cnt_sat, ovf_q, tx_busy, empty, full};
            4'h8:    rdata = {31'd0, en_q};
            default: rdata = '0;
        endcase
    end

    assign apb.PRDATA = (acc & ~apb.PWRITE) ? rdata : 32'd0;
    assign apb.PREADY = 1'b1;

    logic unused_pwdata;
    assign unused_pwdata = ^{apb.PWDATA[31:8]};
endmodule

// File: tb/tb_apb_uart_tx.sv
// Bench for apb_uart_tx: APB reads and decoded UART frames are checked by
// monitors against expectation queues filled by the stimulus process.
module tb_apb_uart_tx;
    logic clk = 1'b0;
    logic reset;
    logic tx, tx_busy;

    apb_uart_tx_if bus ();

    apb_uart_tx #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .apb     (bus),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] v;
    } rd_exp_t;

    rd_exp_t    rd_q [$];
    logic [7:0] byte_q [$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #2;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = a; bus.PWDATA = d;
        @(posedge clk); #2;
        bus.PENABLE = 1'b1;
        @(posedge clk); #2;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input string name, input logic [3:0] a, input logic [31:0] exp);
        rd_exp_t e;
        e.name = name;
        e.v    = exp;
        rd_q.push_back(e);
        @(posedge clk); #2;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
        @(posedge clk); #2;
        bus.PENABLE = 1'b1;
        @(posedge clk); #2;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (byte_q.size() == 0 && !tx_busy) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, done}, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    // Read monitor: compares PRDATA in every read access phase.
    always @(negedge clk) begin
        if (bus.PSEL && bus.PENABLE && !bus.PWRITE) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got %h want none", bus.PRDATA);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk(e.name, bus.PRDATA, e.v);
            end
        end
    end

    // Line monitor: decodes 8N1 frames (DIV=10) sampling mid-bit.
    initial begin
        logic       prev, start_ok, stop_ok;
        logic [7:0] b, e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && tx === 1'b0) begin
                repeat (4) @(negedge clk);
                start_ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = tx;
                end
                repeat (10) @(negedge clk);
                stop_ok = (tx === 1'b1);
                if (byte_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_unexpected: got %h want none", b);
                end else begin
                    e = byte_q.pop_front();
                    chk("frame_byte", {22'd0, start_ok, stop_ok, b}, {22'd0, 1'b1, 1'b1, e});
                end
            end
            prev = tx;
        end
    end

    initial begin
        int nbusy, nlow;
        logic lowrun;
        reset = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;
        repeat (3) @(posedge clk); #2;
        reset = 1'b0;

        // 1: reset state
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_prdata", bus.PRDATA, 32'd0);
        chk("pready", {31'd0, bus.PREADY}, 32'd1);
        apb_rd("rst_status", 4'h4, 32'h2);
        apb_rd("rst_ctrl", 4'h8, 32'h1);
        apb_rd("txdata_rd", 4'h0, 32'h0);
        apb_rd("unmapped_rd", 4'hC, 32'h0);

        // 2: single byte, latency and frame length
        byte_q.push_back(8'h55);
        apb_wr(4'h0, 32'h55);
        @(negedge clk);
        chk("lat_pre", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("lat_fall", {31'd0, tx}, 32'd0);
        chk("lat_busy", {31'd0, tx_busy}, 32'd1);
        nbusy = 1; nlow = 1; lowrun = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!tx_busy) break;
            nbusy++;
            if (lowrun && !tx) nlow++;
            else lowrun = 1'b0;
        end
        chk("busy_len", nbusy, 32'd100);
        chk("start_len", nlow, 32'd10);
        wait_drain("drain_55");

        // 3: overfill; 0x00 popped, 0x01..0x08 queued, 0x09 dropped
        for (int i = 0; i < 10; i++) begin
            if (i < 9) byte_q.push_back(8'(i));
            apb_wr(4'h0, 32'(i));
        end
        apb_rd("status_full_ovf", 4'h4, 32'h8D);

        // 4: clear overflow, then a drop sets it again
        apb_wr(4'h4, 32'h8);
        apb_rd("status_clr", 4'h4, 32'h85);
        apb_wr(4'h0, 32'hEE);
        apb_rd("status_redrop", 4'h4, 32'h8D);
        wait_drain("drain_burst");

        // 5: tx_en gating
        apb_wr(4'h8, 32'h0);
        apb_wr(4'h0, 32'hA3);
        nlow = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) nlow++;
        end
        chk("gated_idle", nlow, 32'd0);
        apb_rd("gated_status", 4'h4, 32'h18);
        apb_rd("gated_ctrl", 4'h8, 32'h0);
        byte_q.push_back(8'hA3);
        apb_wr(4'h8, 32'h1);
        wait_drain("drain_a3");

        // 6: reset mid-frame; the all-ones byte still decodes as 0xFF
        byte_q.push_back(8'hFF);
        apb_wr(4'h0, 32'hFF);
        apb_wr(4'h0, 32'h11);
        apb_wr(4'h0, 32'h22);
        apb_wr(4'h0, 32'h33);
        repeat (26) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_async_tx", {31'd0, tx}, 32'd1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        apb_rd("post_rst_status", 4'h4, 32'h2);
        apb_rd("post_rst_ctrl", 4'h8, 32'h1);
        nlow = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) nlow++;
        end
        chk("post_rst_quiet", nlow, 32'd0);
        chk("frames_left", byte_q.size(), 32'd0);
        chk("reads_left", rd_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
